// File: rtl/led_pwm_sequencer_pkg.sv
// led_pwm_sequencer_pkg: state encoding and default timing constants
// shared by the sequencer top and its GSCLK generator.
package led_pwm_sequencer_pkg;

  localparam int GS_BITS_DEF      = 12;
  localparam int GSCLK_DIV_DEF    = 1;
  localparam int BLANK_CYCLES_DEF = 2;
  localparam int ROWS_DEF         = 8;
  localparam int ROW_WIDTH_DEF    = 3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LOAD       = 3'd1;
  localparam logic [2:0] ST_BLANK_PRE  = 3'd2;
  localparam logic [2:0] ST_XLAT       = 3'd3;
  localparam logic [2:0] ST_BLANK_POST = 3'd4;
  localparam logic [2:0] ST_GS         = 3'd5;

endpackage

// File: rtl/led_pwm_sequencer_if.sv
// led_pwm_sequencer_if: row-data request/complete pulse handshake
// between the sequencer (master) and the serial shift engine (slave).
interface led_pwm_sequencer_if #(
  parameter int ROW_WIDTH = 3
) ();

  logic                 shift_req;
  logic [ROW_WIDTH-1:0] shift_row;
  logic                 shift_done;

  modport master (
    output shift_req,
    output shift_row,
    input  shift_done
  );

  modport slave (
    input  shift_req,
    input  shift_row,
    output shift_done
  );

endinterface

// File: rtl/led_gsclk_gen.sv
// led_gsclk_gen: GSCLK divider and pulse counter; emits exactly
// 2^GS_BITS pulses per start and flags the end of the last low phase.
module led_gsclk_gen #(
  parameter int GS_BITS   = 12,
  parameter int GSCLK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic enable,
  output logic led_gsclk,
  output logic done
);

  localparam int DW = (GSCLK_DIV > 1) ? $clog2(GSCLK_DIV) : 1;
  localparam int CW = GS_BITS + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << GS_BITS) - 1);

  logic [DW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic          gsclk_q;
  logic          phase_end;

  assign phase_end = (div_q == DW'(GSCLK_DIV - 1));
  assign done      = enable && !gsclk_q && phase_end && (cnt_q == LAST);
  assign led_gsclk = gsclk_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= '0;
      cnt_q   <= '0;
      gsclk_q <= 1'b0;
    end else if (start) begin
      div_q   <= '0;
      cnt_q   <= '0;
      gsclk_q <= 1'b1;
    end else if (done || !enable) begin
      div_q   <= '0;
      gsclk_q <= 1'b0;
    end else if (phase_end) begin
      div_q   <= '0;
      gsclk_q <= !gsclk_q;
      // a pulse is complete when its low phase ends
      if (!gsclk_q) cnt_q <= cnt_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_sequencer.sv
// led_pwm_sequencer: GSCLK/BLANK/XLAT timing and row sequencing for a TLC5940 chain.
// Define LED_XERR_EN to synchronise led_xerr into a sticky xerr_flag.
module led_pwm_sequencer
  import led_pwm_sequencer_pkg::*;
#(
  parameter int GS_BITS      = GS_BITS_DEF,
  parameter int GSCLK_DIV    = GSCLK_DIV_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int ROWS         = ROWS_DEF,
  parameter int ROW_WIDTH    = ROW_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 led_xerr,
  led_pwm_sequencer_if.master  shift,
  output logic [ROW_WIDTH-1:0] row_sel,
  output logic                 led_gsclk,
  output logic                 led_blank,
  output logic                 led_xlat,
  output logic                 frame_start,
  output logic                 underrun,
  output logic                 xerr_flag
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        bcnt_q;
  logic                 pending_q, outst_q;
  logic [ROW_WIDTH-1:0] row_q, srow_q;
  logic                 req_q, blank_q, xlat_q;
  logic                 fstart_q, under_q;
  logic                 bp_end, issue, gs_done;

  assign bp_end = (state_q == ST_BLANK_PRE) &&
                  (bcnt_q == BW'(BLANK_CYCLES - 1));

  // never re-request while data is in flight or already waiting
  assign issue = !outst_q && !pending_q &&
                 (((state_q == ST_IDLE) && enable) ||
                  (state_q == ST_BLANK_POST));

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (enable) state_d = ST_LOAD;
      end
      (state_q == ST_LOAD): begin
        if (!enable)        state_d = ST_IDLE;
        else if (pending_q) state_d = ST_BLANK_PRE;
      end
      (state_q == ST_BLANK_PRE): begin
        if (bp_end) begin
          if (!enable)        state_d = ST_IDLE;
          else if (pending_q) state_d = ST_XLAT;
          else                state_d = ST_BLANK_POST;
        end
      end
      (state_q == ST_XLAT):       state_d = ST_BLANK_POST;
      (state_q == ST_BLANK_POST): state_d = ST_GS;
      (state_q == ST_GS): begin
        if (gs_done) state_d = ST_BLANK_PRE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= '0;
      pending_q <= 1'b0;
      outst_q   <= 1'b0;
      row_q     <= '0;
      srow_q    <= '0;
      req_q     <= 1'b0;
      blank_q   <= 1'b1;
      xlat_q    <= 1'b0;
      fstart_q  <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= ((state_q == ST_BLANK_PRE) &&
                  (state_d == ST_BLANK_PRE)) ?
                 bcnt_q + 1'b1 : '0;
      blank_q <= (state_d != ST_GS);
      xlat_q  <= (state_d == ST_XLAT);
      req_q   <= issue;
      outst_q <= issue || (outst_q && !shift.shift_done);
      under_q <= bp_end && enable && !pending_q;
      if (state_q == ST_XLAT)
        pending_q <= 1'b0;
      else if (shift.shift_done && (state_q != ST_IDLE))
        pending_q <= 1'b1;
      fstart_q <= 1'b0;
      if (state_q == ST_XLAT) begin
        row_q    <= srow_q;
        fstart_q <= (srow_q == '0);
        srow_q   <= (srow_q == ROW_WIDTH'(ROWS - 1)) ?
                    '0 : srow_q + 1'b1;
      end
    end
  end

  led_gsclk_gen #(
    .GS_BITS   (GS_BITS),
    .GSCLK_DIV (GSCLK_DIV)
  ) u_gsclk (
    .clock     (clock),
    .reset     (reset),
    .start     (state_q == ST_BLANK_POST),
    .enable    (state_q == ST_GS),
    .led_gsclk (led_gsclk),
    .done      (gs_done)
  );

`ifdef LED_XERR_EN
  logic xs1_q, xs2_q, xerr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      xs1_q  <= 1'b1;
      xs2_q  <= 1'b1;
      xerr_q <= 1'b0;
    end else begin
      xs1_q  <= led_xerr;
      xs2_q  <= xs1_q;
      xerr_q <= xerr_q || ((state_q == ST_GS) && !xs2_q);
    end
  end

  assign xerr_flag = xerr_q;
`else
  assign xerr_flag = 1'b0 & led_xerr;
`endif

  assign shift.shift_req = req_q;
  assign shift.shift_row = srow_q;
  assign row_sel         = row_q;
  assign led_blank       = blank_q;
  assign led_xlat        = xlat_q;
  assign frame_start     = fstart_q;
  assign underrun        = under_q;

endmodule

// File: doc/led_pwm_sequencer.md
Name: led_pwm_sequencer

Overview:
Sequences the TLC5940-style LED driver chain: generates GSCLK, BLANK and XLAT timing for each grayscale PWM cycle, and advances the multiplexed row select. It requests the next row's shift data from the serial shift engine (led_sclk/led_*_sin) through a pulse handshake, and latches that data only when it is complete. It sits between the frame/shift logic and the led_* pins in toplevel.

Parameters:
GS_BITS, 12, grayscale depth; 2^GS_BITS GSCLK rising edges per PWM cycle
GSCLK_DIV, 1, system clocks per GSCLK high phase and per low phase (>=1)
BLANK_CYCLES, 2, clocks BLANK held high before the XLAT slot (>=1)
ROWS, 8, number of multiplexed rows (>=2)
ROW_WIDTH, 3, width of row indices (2^ROW_WIDTH >= ROWS)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run request; level
shift_done  in  1  one-cycle pulse from shift engine: requested row data fully shifted
led_xerr  in  1  driver error, active-low (used only with LED_XERR_EN)
shift_req  out  1  one-cycle pulse: shift data for shift_row
shift_row  out  ROW_WIDTH  row index the shift engine must load
row_sel  out  ROW_WIDTH  currently displayed row
led_gsclk  out  1  grayscale clock
led_blank  out  1  driver blank, high = outputs off
led_xlat  out  1  driver latch strobe
frame_start  out  1  one-cycle pulse when row_sel wraps to 0
underrun  out  1  one-cycle pulse when a PWM cycle ends without shift data
xerr_flag  out  1  sticky driver error flag

Behaviour:
- Reset (any state, overrides all): state IDLE; led_blank=1; led_gsclk=0; led_xlat=0; shift_req=0; frame_start=0; underrun=0; xerr_flag=0; row_sel=0; shift_row=0; pending=0; outstanding=0.
- Internal flags: pending (set on shift_done, cleared on XLAT); outstanding (set on shift_req, cleared on shift_done). shift_done while pending=1 is ignored. shift_done in IDLE is ignored.
- IDLE: blank=1. enable=1 -> LOAD; shift_req pulses on the first LOAD cycle with shift_row=0.
- LOAD: blank=1. Waits for pending -> BLANK_PRE. If enable drops, return to IDLE; an outstanding request stays tracked.
- BLANK_PRE: blank=1 for BLANK_CYCLES clocks. At the end:
  - enable=0 -> IDLE.
  - pending=1 -> XLAT.
  - pending=0 -> underrun pulse, then BLANK_POST; row_sel is unchanged and the same row's latched data is shown again.
- XLAT: exactly one clock; led_xlat=1, blank=1. row_sel <= shift_row and pending <= 0 take effect on the following clock. frame_start pulses in that same following clock if the new row_sel is 0. shift_row <= (shift_row+1) mod ROWS, with wrap at ROWS-1 -> 0.
- BLANK_POST: one clock, blank=1, then GS.
- GS: blank=0. On the first GS clock, shift_req pulses iff outstanding=0 and pending=0.
  - led_gsclk is high GSCLK_DIV clocks, then low GSCLK_DIV clocks.
  - After 2^GS_BITS complete pulses, the last low phase ends and the state goes to BLANK_PRE.
  - The GS counter is GS_BITS+1 wide and never wraps mid-cycle.
  - GS length is exactly 2^GS_BITS*2*GSCLK_DIV clocks. GSCLK is never high while blank=1.
- enable=0 during GS: the current PWM cycle completes, then the sequencer goes to IDLE via BLANK_PRE with no XLAT.
- All outputs are registered.

Optional Feature:
LED_XERR_EN: when defined, led_xerr is double-flop synchronised and sampled only in GS. A synchronised low sets xerr_flag, which clears only on reset. When undefined, led_xerr is ignored and xerr_flag is constant 0.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, BLANK_PRE, XLAT, BLANK_POST, GS) and default constants for GS_BITS, GSCLK_DIV, BLANK_CYCLES, ROWS.
- One sub-module, led_gsclk_gen: divider plus pulse counter. Inputs: start, enable. Outputs: led_gsclk, done.

Test Plan:
- Bench parameters: GS_BITS=4, GSCLK_DIV=1, BLANK_CYCLES=2, ROWS=4.
- Reset mid-GS -> next cycle blank=1, gsclk=0, row_sel=0, xerr_flag=0, state IDLE.
- enable=1, shift_done 3 clocks after each shift_req:
  - one shift_req in LOAD; BLANK_PRE 2 clocks, XLAT 1 clock, BLANK_POST 1 clock.
  - GS: exactly 16 gsclk pulses over 32 clocks.
  - row_sel sequence 0,1,2,3,0; frame_start on each return to 0.
- Withhold shift_done for one cycle -> underrun pulses once, no xlat, row_sel held; no second shift_req issued; next cycle xlats normally.
- Deassert enable mid-GS -> remaining gsclk pulses complete, BLANK_PRE, then IDLE with blank=1, no xlat.
- LED_XERR_EN defined, led_xerr=0 for 3 clocks during GS -> xerr_flag=1 and held; undefined -> xerr_flag stays 0.
